// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg: states, opcodes, ALU selects and IR field positions. Rev 1.0       |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T1W  = 4'd3,
        ST_T2   = 4'd4,
        ST_T3   = 4'd5,
        ST_T4   = 4'd6,
        ST_T5   = 4'd7,
        ST_T6   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHRA = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_NEG  = 5'd9;
    localparam logic [4:0] OP_NOT  = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd11;
    localparam logic [4:0] OP_DIV  = 5'd12;
    localparam logic [4:0] OP_HALT = 5'd31;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SHR  = 4'd4;
    localparam logic [3:0] ALU_SHRA = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_NEG  = 4'd9;
    localparam logic [3:0] ALU_NOT  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;
    localparam logic [3:0] ALU_DIV  = 4'd12;

    localparam int IR_OPC_HI = 31;
    localparam int IR_OPC_LO = 27;
    localparam int IR_RA_HI  = 26;
    localparam int IR_RA_LO  = 23;
    localparam int IR_RB_HI  = 22;
    localparam int IR_RB_LO  = 19;
    localparam int IR_RC_HI  = 18;
    localparam int IR_RC_LO  = 15;

    function automatic logic is_rtype(input logic [4:0] op);
        return (op <= OP_DIV);
    endfunction

    function automatic logic [3:0] alu_select(input logic [4:0] op);
        logic [3:0] sel;
        case (op)
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            OP_SHR:  sel = ALU_SHR;
            OP_SHRA: sel = ALU_SHRA;
            OP_SHL:  sel = ALU_SHL;
            OP_ROR:  sel = ALU_ROR;
            OP_ROL:  sel = ALU_ROL;
            OP_NEG:  sel = ALU_NEG;
            OP_NOT:  sel = ALU_NOT;
            OP_MUL:  sel = ALU_MUL;
            OP_DIV:  sel = ALU_DIV;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_field_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_field_decoder: 4-bit register index to gated one-hot select. Rev 1.0    |
// +----------------------------------------------------------------------------+
module reg_field_decoder
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          idx_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    // Indices beyond NUM_REGS select nothing rather than aliasing a register.
    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_bit
            assign onehot_o[i] = en_i && (32'(idx_i) == i);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_sequencer: Moore fetch/decode/execute control unit. Rev 1.0         |
// +----------------------------------------------------------------------------+
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int         NUM_REGS    = 16,
    parameter logic [4:0] HALT_OPCODE = OP_HALT
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                PCin,
    output logic                PCout,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zlowin,
    output logic                Zhighin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic                Read,
    output logic [3:0]          ALUop,
    output logic                busy,
    output logic                instr_done,
    output logic                halted,
    output logic                illegal
);

    state_t     state_q, state_d;
    logic [4:0] w_opcode;
    logic [3:0] w_ra, w_rb, w_rc;
    logic       w_muldiv, w_unary;
    logic       w_rin_en, w_rout_en;
    logic [3:0] w_rin_idx, w_rout_idx;
    logic       unused_ir_low;

    assign w_opcode      = ir[IR_OPC_HI:IR_OPC_LO];
    assign w_ra          = ir[IR_RA_HI:IR_RA_LO];
    assign w_rb          = ir[IR_RB_HI:IR_RB_LO];
    assign w_rc          = ir[IR_RC_HI:IR_RC_LO];
    assign w_muldiv      = (w_opcode == OP_MUL) || (w_opcode == OP_DIV);
    assign w_unary       = (w_opcode == OP_NEG) || (w_opcode == OP_NOT);
    assign unused_ir_low = ^ir[IR_RC_LO-1:0];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        w_rin_en   = 1'b0;
        w_rin_idx  = 4'd0;
        w_rout_en  = 1'b0;
        w_rout_idx = 4'd0;
        PCin       = 1'b0;
        PCout      = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zlowin     = 1'b0;
        Zhighin    = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        Read       = 1'b0;
        ALUop      = 4'd0;
        busy       = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_T0;
            end
            ST_T0: begin
                busy    = 1'b1;
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zlowin  = 1'b1;
                state_d = ST_T1;
            end
            ST_T1: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = mem_ready ? ST_T2 : ST_T1W;
            end
            // Waiting on memory: PC was already reloaded in T1.
            ST_T1W: begin
                busy  = 1'b1;
                Read  = 1'b1;
                MDRin = 1'b1;
                if (mem_ready) state_d = ST_T2;
            end
            ST_T2: begin
                busy    = 1'b1;
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = ST_T3;
            end
            ST_T3: begin
                busy = 1'b1;
                if (is_rtype(w_opcode)) begin
                    w_rout_en  = 1'b1;
                    w_rout_idx = w_rb;
                    Yin        = 1'b1;
                    state_d    = ST_T4;
                end else if (w_opcode == HALT_OPCODE) begin
                    state_d = ST_HALT;
                end else begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = run ? ST_T0 : ST_IDLE;
                end
            end
            ST_T4: begin
                busy       = 1'b1;
                ALUop      = alu_select(w_opcode);
                Zlowin     = 1'b1;
                Zhighin    = w_muldiv;
                w_rout_en  = 1'b1;
                w_rout_idx = w_unary ? w_rb : w_rc;
                state_d    = ST_T5;
            end
            ST_T5: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                if (w_muldiv) begin
                    LOin    = 1'b1;
                    state_d = ST_T6;
                end else begin
                    w_rin_en   = 1'b1;
                    w_rin_idx  = w_ra;
                    instr_done = 1'b1;
                    state_d    = run ? ST_T0 : ST_IDLE;
                end
            end
            ST_T6: begin
                busy       = 1'b1;
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                instr_done = 1'b1;
                state_d    = run ? ST_T0 : ST_IDLE;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .idx_i    (w_rin_idx),
        .en_i     (w_rin_en),
        .onehot_o (Rin)
    );

    reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
        .idx_i    (w_rout_idx),
        .en_i     (w_rout_en),
        .onehot_o (Rout)
    );

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_control_sequencer: directed per-cycle output checks. Rev 1.0             |
// +----------------------------------------------------------------------------+
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear, run, mem_ready;
    logic [31:0] ir;
    logic [15:0] Rin, Rout;
    logic        PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin;
    logic        Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Read;
    logic [3:0]  ALUop;
    logic        busy, instr_done, halted, illegal;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [18:0] B_PCIN    = 19'h1 << 18;
    localparam logic [18:0] B_PCOUT   = 19'h1 << 17;
    localparam logic [18:0] B_INCPC   = 19'h1 << 16;
    localparam logic [18:0] B_MARIN   = 19'h1 << 15;
    localparam logic [18:0] B_MDRIN   = 19'h1 << 14;
    localparam logic [18:0] B_MDROUT  = 19'h1 << 13;
    localparam logic [18:0] B_IRIN    = 19'h1 << 12;
    localparam logic [18:0] B_YIN     = 19'h1 << 11;
    localparam logic [18:0] B_ZLOWIN  = 19'h1 << 10;
    localparam logic [18:0] B_ZHIGHIN = 19'h1 << 9;
    localparam logic [18:0] B_ZLOWOUT = 19'h1 << 8;
    localparam logic [18:0] B_ZHIOUT  = 19'h1 << 7;
    localparam logic [18:0] B_HIIN    = 19'h1 << 6;
    localparam logic [18:0] B_LOIN    = 19'h1 << 5;
    localparam logic [18:0] B_READ    = 19'h1 << 4;
    localparam logic [18:0] B_BUSY    = 19'h1 << 3;
    localparam logic [18:0] B_DONE    = 19'h1 << 2;
    localparam logic [18:0] B_HALTED  = 19'h1 << 1;
    localparam logic [18:0] B_ILLEGAL = 19'h1 << 0;

    localparam logic [18:0] S_T0  = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN | B_BUSY;
    localparam logic [18:0] S_T1  = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_BUSY;
    localparam logic [18:0] S_T1W = B_READ | B_MDRIN | B_BUSY;
    localparam logic [18:0] S_T2  = B_MDROUT | B_IRIN | B_BUSY;

    logic [63:0] obs;
    assign obs = {9'd0, ALUop, Rin, Rout,
                  PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin,
                  Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Read,
                  busy, instr_done, halted, illegal};

    control_sequencer #(.NUM_REGS(16), .HALT_OPCODE(5'd31)) dut (
        .clock      (clock),
        .clear      (clear),
        .run        (run),
        .mem_ready  (mem_ready),
        .ir         (ir),
        .Rin        (Rin),
        .Rout       (Rout),
        .PCin       (PCin),
        .PCout      (PCout),
        .IncPC      (IncPC),
        .MARin      (MARin),
        .MDRin      (MDRin),
        .MDRout     (MDRout),
        .IRin       (IRin),
        .Yin        (Yin),
        .Zlowin     (Zlowin),
        .Zhighin    (Zhighin),
        .Zlowout    (Zlowout),
        .Zhighout   (Zhighout),
        .HIin       (HIin),
        .LOin       (LOin),
        .Read       (Read),
        .ALUop      (ALUop),
        .busy       (busy),
        .instr_done (instr_done),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] mk(input logic [3:0] alu, input logic [15:0] rin,
                                       input logic [15:0] rout, input logic [18:0] s);
        return {9'd0, alu, rin, rout, s};
    endfunction

    function automatic logic [15:0] oh(input int idx);
        return 16'h1 << idx;
    endfunction

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        return (32'(op) << 27) | (32'(ra) << 23) | (32'(rb) << 19) | (32'(rc) << 15);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [63:0] exp);
        @(negedge clock);
        check(tag, obs, exp);
    endtask

    task automatic fetch(input string tag);
        cyc({tag, "_T0"}, mk(4'd0, 16'd0, 16'd0, S_T0));
        cyc({tag, "_T1"}, mk(4'd0, 16'd0, 16'd0, S_T1));
        cyc({tag, "_T2"}, mk(4'd0, 16'd0, 16'd0, S_T2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1; run = 1'b0; mem_ready = 1'b1; ir = 32'd0;
        cyc("reset", 64'd0);
        cyc("reset_hold", 64'd0);
        clear = 1'b0;
        cyc("idle", 64'd0);

        // ADD R5,R2,R4
        ir = 32'h0292_0000; run = 1'b1;
        fetch("add");
        cyc("add_T3", mk(4'd0, 16'd0, oh(2), B_YIN | B_BUSY));
        cyc("add_T4", mk(4'd0, 16'd0, oh(4), B_ZLOWIN | B_BUSY));
        cyc("add_T5", mk(4'd0, oh(5), 16'd0, B_ZLOWOUT | B_DONE | B_BUSY));
        run = 1'b0;
        cyc("add_idle", 64'd0);

        // MUL R3,R3,R1
        ir = 32'h5998_8000; run = 1'b1;
        fetch("mul");
        cyc("mul_T3", mk(4'd0, 16'd0, oh(3), B_YIN | B_BUSY));
        cyc("mul_T4", mk(4'd11, 16'd0, oh(1), B_ZLOWIN | B_ZHIGHIN | B_BUSY));
        cyc("mul_T5", mk(4'd0, 16'd0, 16'd0, B_ZLOWOUT | B_LOIN | B_BUSY));
        run = 1'b0;
        cyc("mul_T6", mk(4'd0, 16'd0, 16'd0, B_ZHIOUT | B_HIIN | B_DONE | B_BUSY));
        cyc("mul_idle", 64'd0);

        // NOT R7,R6 with three memory wait cycles; rc=2 must not be driven
        ir = mk_ir(10, 7, 6, 2); run = 1'b1; mem_ready = 1'b0;
        cyc("not_T0", mk(4'd0, 16'd0, 16'd0, S_T0));
        cyc("not_T1", mk(4'd0, 16'd0, 16'd0, S_T1));
        cyc("not_T1W_a", mk(4'd0, 16'd0, 16'd0, S_T1W));
        cyc("not_T1W_b", mk(4'd0, 16'd0, 16'd0, S_T1W));
        cyc("not_T1W_c", mk(4'd0, 16'd0, 16'd0, S_T1W));
        mem_ready = 1'b1;
        cyc("not_T2", mk(4'd0, 16'd0, 16'd0, S_T2));
        mem_ready = 1'b0;
        cyc("not_T3", mk(4'd0, 16'd0, oh(6), B_YIN | B_BUSY));
        cyc("not_T4", mk(4'd10, 16'd0, oh(6), B_ZLOWIN | B_BUSY));
        run = 1'b0;
        cyc("not_T5", mk(4'd0, oh(7), 16'd0, B_ZLOWOUT | B_DONE | B_BUSY));
        cyc("not_idle", 64'd0);
        mem_ready = 1'b1;

        // Illegal opcode 20 with run held: returns to T0, then fetch HALT
        ir = mk_ir(20, 3, 4, 5); run = 1'b1;
        fetch("ill");
        cyc("ill_T3", mk(4'd0, 16'd0, 16'd0, B_ILLEGAL | B_DONE | B_BUSY));
        cyc("ill_next_T0", mk(4'd0, 16'd0, 16'd0, S_T0));
        ir = 32'hF800_0000;
        cyc("halt_T1", mk(4'd0, 16'd0, 16'd0, S_T1));
        cyc("halt_T2", mk(4'd0, 16'd0, 16'd0, S_T2));
        cyc("halt_T3", mk(4'd0, 16'd0, 16'd0, B_BUSY));
        for (int i = 0; i < 3; i++) cyc("halted", mk(4'd0, 16'd0, 16'd0, B_HALTED));

        clear = 1'b1;
        cyc("halt_clear", 64'd0);
        clear = 1'b0;

        // Clear asserted mid-ADD in T4: immediate zero, no writeback
        ir = 32'h0292_0000; run = 1'b1;
        fetch("rst");
        cyc("rst_T3", mk(4'd0, 16'd0, oh(2), B_YIN | B_BUSY));
        cyc("rst_T4", mk(4'd0, 16'd0, oh(4), B_ZLOWIN | B_BUSY));
        clear = 1'b1; run = 1'b0;
        #1;
        check("rst_async", obs, 64'd0);
        cyc("rst_hold", 64'd0);
        clear = 1'b0;
        cyc("rst_idle_a", 64'd0);
        cyc("rst_idle_b", 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
